// File: rtl/bp_pkg.sv
// ============================================================================
// Module : bp_pkg
// Brief  : Shared types and constants for the branch target buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_pkg;

  localparam int BP_PC_WIDTH = 32;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t CTR_SNT   = 2'b00;
  localparam bp_ctr_t CTR_WNT   = 2'b01;
  localparam bp_ctr_t CTR_WT    = 2'b10;
  localparam bp_ctr_t CTR_ST    = 2'b11;
  localparam bp_ctr_t CTR_RESET = CTR_WNT;
  localparam bp_ctr_t CTR_ALLOC = CTR_WT;

  // Tag is kept zero-extended to full PC width so one entry type serves any ENTRIES.
  typedef struct packed {
    logic                   valid;
    logic [BP_PC_WIDTH-1:0] tag;
    logic [BP_PC_WIDTH-1:0] target;
    bp_ctr_t                ctr;
  } bp_entry_t;

endpackage

`default_nettype wire

// File: rtl/sat_ctr2.sv
// ============================================================================
// Module : sat_ctr2
// Brief  : 2-bit saturating up/down counter next-state function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_ctr2
  import bp_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    inc_i,
  output bp_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i && (ctr_i != CTR_ST)) begin
      ctr_o = ctr_i + 2'd1;
    end else if (!inc_i && (ctr_i != CTR_SNT)) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module : branch_target_buffer
// Brief  : Direct-mapped BTB with 2-bit direction counters and a saturating
//          mispredict counter; combinational lookup off a flop-based table.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = BP_PC_WIDTH,
  parameter int ENTRIES   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup_en,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 predict_take_branch,
  output logic [PC_WIDTH-1:0]  predict_target_pc,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_taken,
  input  logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 upd_pred_taken,
  input  logic [PC_WIDTH-1:0]  upd_pred_target,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  bp_entry_t              tbl_q [ENTRIES];
  bp_entry_t              upd_entry_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;

  logic [IDX_BITS-1:0]    w_lk_idx;
  logic [PC_WIDTH-1:0]    w_lk_tag;
  bp_entry_t              w_lk_ent;
  logic                   w_lk_hit;
  logic [IDX_BITS-1:0]    w_up_idx;
  logic [PC_WIDTH-1:0]    w_up_tag;
  bp_entry_t              w_up_ent;
  logic                   w_up_hit;
  logic                   w_we;
  logic                   w_mispredict;
  bp_ctr_t                w_ctr_next;
  logic                   w_unused;

  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign w_lk_idx = lookup_pc[IDX_BITS+1:2];
  assign w_lk_tag = {{(IDX_BITS+2){1'b0}}, lookup_pc[PC_WIDTH-1:IDX_BITS+2]};
  assign w_lk_ent = tbl_q[w_lk_idx];
  assign w_lk_hit = lookup_en & w_lk_ent.valid & (w_lk_ent.tag == w_lk_tag);

  assign predict_take_branch = w_lk_hit & w_lk_ent.ctr[1];
  assign predict_target_pc   = predict_take_branch ? w_lk_ent.target : '0;

  assign w_up_idx = upd_pc[IDX_BITS+1:2];
  assign w_up_tag = {{(IDX_BITS+2){1'b0}}, upd_pc[PC_WIDTH-1:IDX_BITS+2]};
  assign w_up_ent = tbl_q[w_up_idx];
  assign w_up_hit = w_up_ent.valid & (w_up_ent.tag == w_up_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr_i (w_up_ent.ctr),
    .inc_i (upd_taken),
    .ctr_o (w_ctr_next)
  );

  always_comb begin
    upd_entry_d = w_up_ent;
    w_we        = 1'b0;
    if (upd_valid) begin
      if (w_up_hit) begin
        w_we            = 1'b1;
        upd_entry_d.ctr = w_ctr_next;
        if (upd_taken) begin
          upd_entry_d.target = upd_target;
        end
      end else if (upd_taken) begin
        w_we               = 1'b1;
        upd_entry_d.valid  = 1'b1;
        upd_entry_d.tag    = w_up_tag;
        upd_entry_d.target = upd_target;
        upd_entry_d.ctr    = CTR_ALLOC;
      end
    end
  end

  assign w_mispredict = upd_valid &
                        ((upd_pred_taken != upd_taken) |
                         (upd_taken & (upd_pred_target != upd_target)));

  assign cnt_d = (w_mispredict && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
      cnt_q <= '0;
    end else begin
      if (w_we) begin
        tbl_q[w_up_idx] <= upd_entry_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule

`default_nettype wire
